// File: rtl/enemy_shot_scheduler.sv
// Round-robin enemy missile launcher: shares a small pool of missile slots among
// alive enemies, with a handshake to the missile logic and a post-launch cooldown.
module enemy_shot_scheduler #(
    parameter int N_ENEMIES = 8,
    parameter int IDX_W     = 3,
    parameter int N_SLOTS   = 4,
    parameter int SLOT_W    = 2,
    parameter int COOLDOWN  = 3000
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic                 shot_req,
    input  logic [N_ENEMIES-1:0] alive,
    input  logic [N_SLOTS-1:0]   slot_done,
    input  logic                 launch_ready,
    output logic                 launch_valid,
    output logic [IDX_W-1:0]     launch_enemy,
    output logic [SLOT_W-1:0]    launch_slot,
    output logic [N_SLOTS-1:0]   slot_busy,
    output logic                 busy
);

    localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CD_W-1:0] CD_LAST = CD_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_PICK, S_LAUNCH, S_COOL} state_t;

    state_t               state, state_nxt;
    logic                 pending, pending_nxt;
    logic                 shot_req_d;
    logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt;
    logic [CD_W-1:0]      cd_cnt, cd_cnt_nxt;
    logic                 valid_nxt;
    logic [IDX_W-1:0]     enemy_nxt;
    logic [SLOT_W-1:0]    slot_nxt;
    logic [N_SLOTS-1:0]   busy_nxt;
    logic [N_SLOTS-1:0]   set_mask;
    logic                 req_edge;

    logic                 pick_found;
    logic [IDX_W-1:0]     pick_enemy;
    logic [IDX_W-1:0]     scan_idx;
    logic [SLOT_W-1:0]    pick_slot;

    assign req_edge = shot_req & ~shot_req_d;
    assign busy     = (state != S_IDLE);

    // Wrapping scan starting at rr_ptr; modulo keeps non-power-of-2 counts in range.
    always_comb begin
        pick_found = 1'b0;
        pick_enemy = '0;
        scan_idx   = '0;
        for (int unsigned k = 0; k < N_ENEMIES; k++) begin
            scan_idx = IDX_W'((32'(rr_ptr) + k) % N_ENEMIES);
            if (!pick_found && alive[scan_idx]) begin
                pick_found = 1'b1;
                pick_enemy = scan_idx;
            end
        end
    end

    always_comb begin
        pick_slot = '0;
        for (int unsigned s = N_SLOTS; s > 0; s--) begin
            if (!slot_busy[s-1]) pick_slot = SLOT_W'(s - 1);
        end
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        cd_cnt_nxt = cd_cnt;
        valid_nxt  = launch_valid;
        enemy_nxt  = launch_enemy;
        slot_nxt   = launch_slot;
        set_mask   = '0;

        case (state)
            S_IDLE: begin
                if (pending) state_nxt = S_PICK;
            end
            S_PICK: begin
                if (!pick_found || (&slot_busy)) begin
                    state_nxt = S_IDLE;
                end else begin
                    enemy_nxt = pick_enemy;
                    slot_nxt  = pick_slot;
                    valid_nxt = 1'b1;
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (launch_ready) begin
                    valid_nxt  = 1'b0;
                    set_mask   = N_SLOTS'(1) << launch_slot;
                    rr_ptr_nxt = (launch_enemy == IDX_W'(N_ENEMIES - 1)) ? '0 : launch_enemy + 1'b1;
                    cd_cnt_nxt = '0;
                    state_nxt  = (COOLDOWN == 0) ? S_IDLE : S_COOL;
                end else if (!alive[launch_enemy]) begin
                    valid_nxt = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            S_COOL: begin
                if (cd_cnt == CD_LAST) state_nxt = S_IDLE;
                else                   cd_cnt_nxt = cd_cnt + 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase

        // A pending request is consumed in IDLE; edges arriving while one is held are lost.
        pending_nxt = pending;
        if (state == S_IDLE && pending) pending_nxt = 1'b0;
        else if (req_edge)              pending_nxt = 1'b1;

        busy_nxt = (slot_busy & ~slot_done) | set_mask;
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            pending      <= 1'b0;
            shot_req_d   <= 1'b0;
            rr_ptr       <= '0;
            cd_cnt       <= '0;
            launch_valid <= 1'b0;
            launch_enemy <= '0;
            launch_slot  <= '0;
            slot_busy    <= '0;
        end else begin
            state        <= state_nxt;
            pending      <= pending_nxt;
            shot_req_d   <= shot_req;
            rr_ptr       <= rr_ptr_nxt;
            cd_cnt       <= cd_cnt_nxt;
            launch_valid <= valid_nxt;
            launch_enemy <= enemy_nxt;
            launch_slot  <= slot_nxt;
            slot_busy    <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_enemy_shot_scheduler.sv
// Bench for enemy_shot_scheduler: directed scenarios plus random traffic, every
// cycle compared against a transaction-level reference model.
module tb_enemy_shot_scheduler;

    localparam int NE = 8;
    localparam int NS = 4;
    localparam int CD = 4;

    localparam int M_IDLE = 0, M_PICK = 1, M_LAUNCH = 2, M_COOL = 3;

    logic          pclk = 1'b0;
    logic          rst = 1'b0;
    logic          shot_req = 1'b0;
    logic [NE-1:0] alive = '0;
    logic [NS-1:0] slot_done = '0;
    logic          launch_ready = 1'b0;
    logic          launch_valid;
    logic [2:0]    launch_enemy;
    logic [1:0]    launch_slot;
    logic [NS-1:0] slot_busy;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int            m_stage;
    bit            m_pend, m_srd, m_valid;
    int            m_enemy, m_slot, m_ptr, m_left;
    logic [NS-1:0] m_busy;

    enemy_shot_scheduler #(
        .N_ENEMIES(NE), .IDX_W(3), .N_SLOTS(NS), .SLOT_W(2), .COOLDOWN(CD)
    ) dut (
        .pclk(pclk), .rst(rst), .shot_req(shot_req), .alive(alive),
        .slot_done(slot_done), .launch_ready(launch_ready),
        .launch_valid(launch_valid), .launch_enemy(launch_enemy),
        .launch_slot(launch_slot), .slot_busy(slot_busy), .busy(busy)
    );

    always #5 pclk = ~pclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stage = M_IDLE; m_pend = 0; m_srd = 0; m_valid = 0;
        m_enemy = 0; m_slot = 0; m_ptr = 0; m_left = 0; m_busy = '0;
    endtask

    task automatic model_step();
        bit            req_e, pend_old, found;
        int            st, e;
        logic [NS-1:0] set;
        req_e    = shot_req && !m_srd;
        pend_old = m_pend;
        st       = m_stage;
        set      = '0;
        m_srd    = shot_req;
        case (st)
            M_IDLE: if (pend_old) m_stage = M_PICK;
            M_PICK: begin
                if (alive == '0 || m_busy == '1) begin
                    m_stage = M_IDLE;
                end else begin
                    found = 0;
                    for (int k = 0; k < NE; k++) begin
                        e = (m_ptr + k) % NE;
                        if (!found && alive[3'(e)]) begin found = 1; m_enemy = e; end
                    end
                    found = 0;
                    for (int s = 0; s < NS; s++) begin
                        if (!found && !m_busy[2'(s)]) begin found = 1; m_slot = s; end
                    end
                    m_valid = 1;
                    m_stage = M_LAUNCH;
                end
            end
            M_LAUNCH: begin
                if (launch_ready) begin
                    m_valid = 0;
                    set[2'(m_slot)] = 1'b1;
                    m_ptr   = (m_enemy + 1) % NE;
                    m_left  = CD;
                    m_stage = (CD == 0) ? M_IDLE : M_COOL;
                end else if (!alive[3'(m_enemy)]) begin
                    m_valid = 0;
                    m_stage = M_IDLE;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_stage = M_IDLE;
            end
        endcase
        if (st == M_IDLE && pend_old) m_pend = 0;
        else if (req_e && !pend_old)  m_pend = 1;
        m_busy = (m_busy & ~slot_done) | set;
    endtask

    task automatic check_all();
        check_eq("valid", launch_valid, m_valid);
        if (m_valid) begin
            check_eq("enemy", launch_enemy, m_enemy);
            check_eq("slot", launch_slot, m_slot);
        end
        check_eq("slot_busy", slot_busy, m_busy);
        check_eq("busy", busy, m_stage != M_IDLE);
    endtask

    task automatic step();
        @(posedge pclk);
        if (rst) model_step();
        else     model_reset();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_valid"}, launch_valid, 0);
        check_eq({tag, "_enemy"}, launch_enemy, 0);
        check_eq({tag, "_slot"}, launch_slot, 0);
        check_eq({tag, "_sbusy"}, slot_busy, 0);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1 check_zero_outputs("rst");
        model_reset();
        step();
        rst = 1'b1;
        shot_req = 1'b0; slot_done = '0;
        step();
    endtask

    // Raises shot_req and waits (bounded) for the offer; shot_req is dropped afterwards.
    task automatic wait_launch(input string tag, input int exp_e, input int exp_s);
        int cnt = 0;
        shot_req = 1'b1;
        step();
        while (!launch_valid && cnt < 20) begin
            step();
            cnt++;
        end
        shot_req = 1'b0;
        check_eq({tag, "_offer"}, launch_valid, 1);
        check_eq({tag, "_enemy"}, launch_enemy, exp_e);
        check_eq({tag, "_slot"}, launch_slot, exp_s);
    endtask

    initial begin
        model_reset();
        #1 check_zero_outputs("init");
        idle(2);
        rst = 1'b1;
        step();

        // T1: single enemy, latency and slot occupancy
        alive = 8'h01; launch_ready = 1'b1;
        shot_req = 1'b1;
        step();
        check_eq("t1_e0", launch_valid, 0);
        step();
        check_eq("t1_e1", launch_valid, 0);
        step();
        check_eq("t1_e2_valid", launch_valid, 1);
        check_eq("t1_enemy", launch_enemy, 0);
        check_eq("t1_slot", launch_slot, 0);
        step();
        check_eq("t1_sbusy", slot_busy, 4'b0001);
        check_eq("t1_busy", busy, 1);
        shot_req = 1'b0;
        idle(CD + 2);

        // T2: round robin across three requests
        do_reset();
        alive = 8'hFF; launch_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_launch("t2", i, i);
            idle(10);
        end
        check_eq("t2_sbusy", slot_busy, 4'b0111);

        // T3: all slots busy drops the request, then freed slot is reused
        wait_launch("t3_fill", 3, 3);
        idle(10);
        check_eq("t3_full", slot_busy, 4'hF);
        shot_req = 1'b1;
        idle(6);
        shot_req = 1'b0;
        check_eq("t3_dropped", launch_valid, 0);
        check_eq("t3_idle", busy, 0);
        slot_done = 4'b0100;
        step();
        slot_done = '0;
        step();
        wait_launch("t3", 4, 2);
        idle(10);

        // T4: stall, then abort when the enemy dies
        do_reset();
        alive = 8'hFF; launch_ready = 1'b0;
        wait_launch("t4a", 0, 0);
        idle(5);
        check_eq("t4_hold_e", launch_enemy, 0);
        launch_ready = 1'b1;
        step();
        launch_ready = 1'b0;
        check_eq("t4_once", launch_valid, 0);
        check_eq("t4_sbusy", slot_busy, 4'b0001);
        idle(CD + 2);
        wait_launch("t4b", 1, 1);
        idle(2);
        alive = 8'hFD;
        step();
        check_eq("t4_abort", launch_valid, 0);
        check_eq("t4_abort_sb", slot_busy, 4'b0001);
        alive = 8'hFF;
        idle(4);

        // T5: pointer wrap from enemy 7 to enemy 0
        do_reset();
        alive = 8'h40; launch_ready = 1'b1;
        wait_launch("t5a", 6, 0);
        idle(CD + 3);
        alive = 8'h81;
        wait_launch("t5b", 7, 1);
        idle(CD + 3);
        wait_launch("t5c", 0, 2);
        idle(CD + 3);

        // T6: asynchronous reset during LAUNCH and during COOLDOWN
        do_reset();
        alive = 8'hFF; launch_ready = 1'b0;
        wait_launch("t6a", 0, 0);
        do_reset();
        launch_ready = 1'b1;
        wait_launch("t6b", 0, 0);
        idle(2);
        check_eq("t6_cool", busy, 1);
        do_reset();
        wait_launch("t6c", 0, 0);
        idle(CD + 3);

        // random traffic
        do_reset();
        alive = 8'hFF;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom % 4 == 0) shot_req = ~shot_req;
            launch_ready = ($urandom % 3) != 0;
            if ($urandom % 50 == 0) alive = 8'($urandom);
            slot_done = ($urandom % 6 == 0) ? (4'($urandom) & m_busy) : '0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
